vregfile_masked: RTL and testbench
==================================

VREGFILE_MASKED -- requirements
Module: vregfile_masked

Interface
REQ-001 SHALL have parameter LANES, default 8, number of lanes per vector register.
REQ-002 SHALL have parameter LANE_W, default 32, bits per lane; VW = LANES*LANE_W.
REQ-003 SHALL have parameter NREGS, default 8, number of vector registers.
REQ-004 SHALL have parameter BASE, default 16, architectural index of the first vector register.
REQ-005 SHALL have ports: clk  in  1  clock (one clock; all state on rising edge).
REQ-006 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: vra1, vra2  in  5  read addresses; vrd1, vrd2  out  VW  read data.
REQ-008 SHALL have ports: vwe3  in  1, vwa3  in  5, vwd3  in  VW, vwmask3  in  LANES  (masked write port).
REQ-009 SHALL have ports: iss_valid  in  1, iss_addr  in  5  (mark destination pending).
REQ-010 SHALL have ports: pend1, pend2  out  1  (register at vra1/vra2 has a pending write).
REQ-011 SHALL have ports: clr_req  in  1  (start clear sequence); clr_busy  out  1.

Function
REQ-012 SHALL treat an address as valid iff BASE <= addr <= BASE+NREGS-1; index = addr-BASE.
REQ-013 SHALL read combinationally (0-cycle); invalid read address returns all zeros and pend=0.
REQ-014 SHALL write on the rising edge when vwe3=1, address valid, clr_busy=0: only lanes with vwmask3[i]=1 are updated; other lanes keep their value.
REQ-015 SHALL ignore writes to invalid addresses and all writes while clr_busy=1.
REQ-016 SHALL bypass: if an accepted write targets vra1 (vra2), lanes with mask=1 show vwd3 on vrd1 (vrd2) in the same cycle; unmasked lanes show stored data.
REQ-017 SHALL hold one pending bit per register: iss_valid with valid iss_addr sets it; accepted write to that register clears it; simultaneous set and clear on the same register: set wins.
REQ-018 SHALL drive pend1/pend2 from stored pending bits (no bypass of same-cycle set/clear).
REQ-019 SHALL implement FSM IDLE/CLEAR: IDLE->CLEAR when clr_req=1; in CLEAR zero register idx and its pending bit, one per cycle, idx 0..NREGS-1; CLEAR->IDLE after idx NREGS-1.
REQ-020 SHALL assert clr_busy=1 exactly in state CLEAR (NREGS cycles); clr_req while busy is ignored.
REQ-021 SHALL ignore iss_valid while clr_busy=1.
REQ-022 SHALL return current contents to reads during CLEAR (already-cleared registers read zero).

Reset
REQ-023 SHALL on rst=1 at a rising edge zero all registers and pending bits in one cycle, set FSM to IDLE, idx=0; clr_busy=0, pend1/pend2=0, vrd1/vrd2=0 after.
REQ-024 SHALL give rst priority over writes, issue and clear; rst mid-CLEAR aborts to IDLE.

Structure
REQ-025 SHALL place the FSM state enum and default LANES/LANE_W/NREGS/BASE constants in shared package vreg_pkg.
REQ-026 SHALL use one sub-module vreg_clear_seq (FSM + idx counter, outputs clr_busy, clr_en, clr_idx).
REQ-027 SHALL store storage as NREGS x LANES x LANE_W array; no latches.

Verification
REQ-028 SHALL test reset: write all registers, assert rst -> every valid address reads 0, pend=0, clr_busy=0.
REQ-029 SHALL test masked write: v16 = all 0xAAAAAAAA, write v16 0x5555... mask 8'h0F -> lanes 0-3 = 0x55555555, lanes 4-7 = 0xAAAAAAAA; same-cycle read shows identical value via bypass.
REQ-030 SHALL test addresses: write v15 and v24 -> no state change; read v15/v24 -> 0.
REQ-031 SHALL test scoreboard: iss v18 -> pend1=1 next cycle at vra1=18; write v18 with iss v18 same cycle -> pend stays 1; write alone -> pend 0.
REQ-032 SHALL test clear: fill all, pulse clr_req -> clr_busy high 8 cycles, v16+k reads 0 from cycle k+1; write during busy ignored.
REQ-033 SHALL test rst at cycle 3 of CLEAR -> IDLE, clr_busy=0, all registers 0.

Source files
------------

// File: rtl/vreg_pkg.sv
// Shared constants and clear-sequencer state type for the masked vector register file.
package vreg_pkg;

  localparam int DEF_LANES  = 8;
  localparam int DEF_LANE_W = 32;
  localparam int DEF_NREGS  = 8;
  localparam int DEF_BASE   = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/vreg_clear_seq.sv
// Clear sequencer: walks register indices 0..NREGS-1, one per cycle, after clr_req.
module vreg_clear_seq
  import vreg_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_en,
  output logic [IDX_W-1:0] clr_idx
);

  clr_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      clr_busy <= 1'b0;
      clr_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_CLEAR;
            clr_busy <= 1'b1;
            clr_idx  <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_idx == IDX_W'(NREGS - 1)) begin
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
            clr_idx  <= '0;
          end else begin
            clr_idx <= clr_idx + IDX_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          clr_busy <= 1'b0;
          clr_idx  <= '0;
        end
      endcase
    end
  end

  assign clr_en = clr_busy;

endmodule

// File: rtl/vregfile_masked.sv
// Vector register file with per-lane write mask, write-to-read bypass,
// per-register pending scoreboard and a sequential clear engine.
module vregfile_masked
  import vreg_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int BASE   = DEF_BASE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              vra1,
  input  logic [4:0]              vra2,
  output logic [LANES*LANE_W-1:0] vrd1,
  output logic [LANES*LANE_W-1:0] vrd2,
  input  logic                    vwe3,
  input  logic [4:0]              vwa3,
  input  logic [LANES*LANE_W-1:0] vwd3,
  input  logic [LANES-1:0]        vwmask3,
  input  logic                    iss_valid,
  input  logic [4:0]              iss_addr,
  output logic                    pend1,
  output logic                    pend2,
  input  logic                    clr_req,
  output logic                    clr_busy
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [LANES-1:0][LANE_W-1:0] mem [NREGS];
  logic [NREGS-1:0]             pend_q;

  logic             clr_en;
  logic [IDX_W-1:0] clr_idx;

  function automatic logic addr_ok(input logic [4:0] a);
    return ({27'b0, a} >= 32'(BASE)) && ({27'b0, a} <= 32'(BASE + NREGS - 1));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [4:0] a);
    return IDX_W'(a - 5'(BASE));
  endfunction

  vreg_clear_seq #(
    .NREGS (NREGS),
    .IDX_W (IDX_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_en   (clr_en),
    .clr_idx  (clr_idx)
  );

  logic             wr_acc, iss_ok, rd1_ok, rd2_ok, byp1, byp2;
  logic [IDX_W-1:0] wr_idx, iss_idx, rd1_idx, rd2_idx;

  assign wr_acc  = vwe3 && addr_ok(vwa3) && !clr_busy;
  assign iss_ok  = iss_valid && addr_ok(iss_addr) && !clr_busy;
  assign rd1_ok  = addr_ok(vra1);
  assign rd2_ok  = addr_ok(vra2);
  assign wr_idx  = addr_idx(vwa3);
  assign iss_idx = addr_idx(iss_addr);
  assign rd1_idx = addr_idx(vra1);
  assign rd2_idx = addr_idx(vra2);
  assign byp1    = wr_acc && (vwa3 == vra1);
  assign byp2    = wr_acc && (vwa3 == vra2);

  always_comb begin
    vrd1 = '0;
    vrd2 = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (rd1_ok)
        vrd1[l*LANE_W +: LANE_W] = (byp1 && vwmask3[l]) ? vwd3[l*LANE_W +: LANE_W]
                                                        : mem[rd1_idx][l];
      if (rd2_ok)
        vrd2[l*LANE_W +: LANE_W] = (byp2 && vwmask3[l]) ? vwd3[l*LANE_W +: LANE_W]
                                                        : mem[rd2_idx][l];
    end
  end

  assign pend1 = rd1_ok ? pend_q[rd1_idx] : 1'b0;
  assign pend2 = rd2_ok ? pend_q[rd2_idx] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) mem[r] <= '0;
      pend_q <= '0;
    end else begin
      // Writes and issues are blocked while clearing, so the clear never collides with them.
      if (clr_en) begin
        mem[clr_idx]    <= '0;
        pend_q[clr_idx] <= 1'b0;
      end else begin
        if (wr_acc) begin
          for (int unsigned l = 0; l < LANES; l++)
            if (vwmask3[l]) mem[wr_idx][l] <= vwd3[l*LANE_W +: LANE_W];
          pend_q[wr_idx] <= 1'b0;
        end
        if (iss_ok) pend_q[iss_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vregfile_masked.sv
// Directed bench for vregfile_masked with a per-cycle reference model and literal spot checks.
module tb_vregfile_masked;

  localparam int LANES = 8;
  localparam int LW    = 32;
  localparam int VW    = LANES * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    vra1, vra2, vwa3, iss_addr;
  logic [VW-1:0] vrd1, vrd2, vwd3;
  logic          vwe3, iss_valid, clr_req;
  logic [LANES-1:0] vwmask3;
  logic          pend1, pend2, clr_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vregfile_masked #(
    .LANES  (8),
    .LANE_W (32),
    .NREGS  (8),
    .BASE   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vra1      (vra1),
    .vra2      (vra2),
    .vrd1      (vrd1),
    .vrd2      (vrd2),
    .vwe3      (vwe3),
    .vwa3      (vwa3),
    .vwd3      (vwd3),
    .vwmask3   (vwmask3),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .pend1     (pend1),
    .pend2     (pend2),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy)
  );

  // Reference model: architectural contents, pending bits, clear progress.
  logic [VW-1:0] m_mem [8];
  bit            m_pend [8];
  bit            m_busy;
  int            m_next;
  bit            model_ok = 0;
  bit            m_acc, m_iss;

  function automatic bit a_ok(input logic [4:0] a);
    return (a >= 5'd16) && (a <= 5'd23);
  endfunction

  function automatic logic [VW-1:0] exp_rd(input logic [4:0] a);
    logic [VW-1:0] r;
    if (!a_ok(a)) return '0;
    r = m_mem[int'(a) - 16];
    if (vwe3 && a_ok(vwa3) && !m_busy && vwa3 == a)
      for (int l = 0; l < LANES; l++)
        if (vwmask3[l]) r[l*LW +: LW] = vwd3[l*LW +: LW];
    return r;
  endfunction

  function automatic bit exp_pend(input logic [4:0] a);
    return a_ok(a) ? m_pend[int'(a) - 16] : 1'b0;
  endfunction

  function automatic logic [VW-1:0] fv(input int k);
    logic [VW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*LW +: LW] = 32'hF000_0000 | (k << 8) | l;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
      m_busy   = 1'b0;
      m_next   = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_acc = vwe3 && a_ok(vwa3) && !m_busy;
      m_iss = iss_valid && a_ok(iss_addr) && !m_busy;
      if (m_acc) begin
        for (int l = 0; l < LANES; l++)
          if (vwmask3[l]) m_mem[int'(vwa3) - 16][l*LW +: LW] = vwd3[l*LW +: LW];
        m_pend[int'(vwa3) - 16] = 1'b0;
      end
      if (m_iss) m_pend[int'(iss_addr) - 16] = 1'b1;
      if (m_busy) begin
        m_mem[m_next]  = '0;
        m_pend[m_next] = 1'b0;
        m_next++;
        if (m_next == 8) m_busy = 1'b0;
      end else if (clr_req) begin
        m_busy = 1'b1;
        m_next = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_vrd1", vrd1, exp_rd(vra1));
      chk("model_vrd2", vrd2, exp_rd(vra2));
      chk("model_pend1", VW'(pend1), VW'(exp_pend(vra1)));
      chk("model_pend2", VW'(pend2), VW'(exp_pend(vra2)));
      chk("model_busy", VW'(clr_busy), VW'(m_busy));
    end
  end

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [VW-1:0] d, input logic [LANES-1:0] m);
    vwe3 = 1'b1; vwa3 = a; vwd3 = d; vwmask3 = m;
    settle; adv;
    vwe3 = 1'b0;
  endtask

  task automatic fill_all;
    for (int k = 0; k < 8; k++) wr(5'(16 + k), fv(k), 8'hFF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; vwe3 = 1'b0; iss_valid = 1'b0; clr_req = 1'b0;
    vwa3 = 5'd0; vwd3 = '0; vwmask3 = '0; iss_addr = 5'd0;
    vra1 = 5'd16; vra2 = 5'd17;
    adv;
    rst = 1'b0;
    settle;
    chk("reset_vrd1", vrd1, '0);
    chk("reset_busy", VW'(clr_busy), '0);
    chk("reset_pend1", VW'(pend1), '0);
    adv;

    // Reset clears every register and pending bit.
    fill_all;
    iss_valid = 1'b1; iss_addr = 5'd20; settle; adv; iss_valid = 1'b0;
    vra1 = 5'd20; settle;
    chk("pre_rst_pend", VW'(pend1), VW'(1));
    chk("pre_rst_data", vrd1, fv(4));
    adv;
    rst = 1'b1; settle; adv; rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      vra1 = 5'(16 + k); vra2 = 5'(23 - k);
      settle;
      chk("rst_all_vrd1", vrd1, '0);
      chk("rst_all_pend1", VW'(pend1), '0);
      adv;
    end

    // Masked write with same-cycle bypass.
    wr(5'd16, {8{32'hAAAA_AAAA}}, 8'hFF);
    vwe3 = 1'b1; vwa3 = 5'd16; vwd3 = {8{32'h5555_5555}}; vwmask3 = 8'h0F;
    vra1 = 5'd16; vra2 = 5'd16;
    settle;
    chk("mask_bypass1", vrd1, {{4{32'hAAAA_AAAA}}, {4{32'h5555_5555}}});
    chk("mask_bypass2", vrd2, {{4{32'hAAAA_AAAA}}, {4{32'h5555_5555}}});
    adv;
    vwe3 = 1'b0;
    settle;
    chk("mask_stored", vrd1, {{4{32'hAAAA_AAAA}}, {4{32'h5555_5555}}});
    adv;

    // Out-of-range addresses.
    vra1 = 5'd15; vra2 = 5'd24;
    vwe3 = 1'b1; vwa3 = 5'd15; vwd3 = {8{32'hDEAD_BEEF}}; vwmask3 = 8'hFF;
    iss_valid = 1'b1; iss_addr = 5'd24;
    settle;
    chk("inval_rd15", vrd1, '0);
    chk("inval_rd24", vrd2, '0);
    adv;
    vwa3 = 5'd24; iss_addr = 5'd15; settle; adv;
    vwe3 = 1'b0; iss_valid = 1'b0;
    settle;
    chk("inval_pend24", VW'(pend2), '0);
    adv;
    vra1 = 5'd16; settle;
    chk("inval_no_change", vrd1, {{4{32'hAAAA_AAAA}}, {4{32'h5555_5555}}});
    adv;
    wr(5'd23, fv(7), 8'h80);
    for (int k = 0; k < 8; k++) begin
      vra1 = 5'(16 + k); settle; adv;
    end

    // Scoreboard set/clear ordering.
    vra1 = 5'd18; vra2 = 5'd19;
    iss_valid = 1'b1; iss_addr = 5'd18;
    settle; chk("sb_not_yet", VW'(pend1), '0); adv;
    iss_valid = 1'b0;
    settle; chk("sb_set", VW'(pend1), VW'(1)); adv;
    vwe3 = 1'b1; vwa3 = 5'd18; vwd3 = fv(2); vwmask3 = 8'hFF;
    iss_valid = 1'b1; iss_addr = 5'd18;
    settle; adv;
    vwe3 = 1'b0; iss_valid = 1'b0;
    settle; chk("sb_set_wins", VW'(pend1), VW'(1)); adv;
    wr(5'd18, fv(3), 8'h01);
    settle;
    chk("sb_cleared", VW'(pend1), '0);
    chk("sb_other", VW'(pend2), '0);
    adv;

    // Clear sequence with ignored writes, issues and re-requests.
    fill_all;
    clr_req = 1'b1; settle; chk("clr_start_idle", VW'(clr_busy), '0); adv;
    clr_req = 1'b0;
    for (int j = 0; j < 8; j++) begin
      vra1 = 5'(16 + ((j == 0) ? 0 : j - 1));
      vra2 = 5'(16 + j);
      vwe3 = 1'b1; vwa3 = 5'd23; vwd3 = {8{32'h1234_5678}}; vwmask3 = 8'hFF;
      iss_valid = 1'b1; iss_addr = 5'd20;
      clr_req = (j == 3);
      settle;
      chk("clr_busy_hi", VW'(clr_busy), VW'(1));
      chk("clr_prev", vrd1, (j == 0) ? fv(0) : '0);
      chk("clr_cur", vrd2, fv(j));
      adv;
    end
    vwe3 = 1'b0; iss_valid = 1'b0; clr_req = 1'b0;
    vra1 = 5'd23; vra2 = 5'd20;
    settle;
    chk("clr_done", VW'(clr_busy), '0);
    chk("clr_wr_ignored", vrd1, '0);
    chk("clr_iss_ignored", VW'(pend2), '0);
    adv;
    settle; chk("clr_no_retrigger", VW'(clr_busy), '0); adv;

    // Reset in the middle of a clear.
    fill_all;
    clr_req = 1'b1; settle; adv; clr_req = 1'b0;
    for (int j = 0; j < 3; j++) begin settle; adv; end
    rst = 1'b1; settle; adv; rst = 1'b0;
    settle; chk("rst_mid_busy", VW'(clr_busy), '0); adv;
    for (int k = 0; k < 8; k++) begin
      vra1 = 5'(16 + k); settle;
      chk("rst_mid_vrd1", vrd1, '0);
      adv;
    end

    // Sparse mask bypass on port 2.
    wr(5'd21, fv(1), 8'hFF);
    vwe3 = 1'b1; vwa3 = 5'd21; vwd3 = {8{32'h0F0F_0F0F}}; vwmask3 = 8'hA5;
    vra1 = 5'd22; vra2 = 5'd21;
    settle;
    chk("sparse_bypass", vrd2, {32'h0F0F_0F0F, 32'hF000_0106, 32'h0F0F_0F0F, 32'hF000_0104,
                                32'hF000_0103, 32'h0F0F_0F0F, 32'hF000_0101, 32'h0F0F_0F0F});
    adv;
    vwe3 = 1'b0; settle; adv;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
